// File: rtl/interface_ov7670_uc_if.sv
// Signal bundle between the OV7670 capture control unit and its datapath/camera side.
// The master modport is the control unit; the slave modport is the datapath plus
// whatever supplies the start request and camera strobes.
interface interface_ov7670_uc_if;
  // requests and strobes into the control unit
  logic       iniciar;
  logic       transmite_frame;
  logic       transmite_byte;
  logic       match_pixel;
  logic       fim_coluna_pixel;
  logic       fim_linha_pixel;
  logic       fim_coluna_quadrante;
  logic       fim_linha_quadrante;
  // datapath controls and status from the control unit
  logic       byte_estavel;
  logic       zera_linha_pixel;
  logic       zera_coluna_pixel;
  logic       zera_linha_quadrante;
  logic       zera_coluna_quadrante;
  logic       conta_linha_pixel;
  logic       conta_coluna_pixel;
  logic       conta_linha_quadrante;
  logic       conta_coluna_quadrante;
  logic       pronto;
  logic       erro;
  logic       overrun;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, transmite_frame, transmite_byte, match_pixel,
           fim_coluna_pixel, fim_linha_pixel, fim_coluna_quadrante, fim_linha_quadrante,
    output byte_estavel,
           zera_linha_pixel, zera_coluna_pixel, zera_linha_quadrante, zera_coluna_quadrante,
           conta_linha_pixel, conta_coluna_pixel, conta_linha_quadrante, conta_coluna_quadrante,
           pronto, erro, overrun, db_estado
  );

  modport slave (
    output iniciar, transmite_frame, transmite_byte, match_pixel,
           fim_coluna_pixel, fim_linha_pixel, fim_coluna_quadrante, fim_linha_quadrante,
    input  byte_estavel,
           zera_linha_pixel, zera_coluna_pixel, zera_linha_quadrante, zera_coluna_quadrante,
           conta_linha_pixel, conta_coluna_pixel, conta_linha_quadrante, conta_coluna_quadrante,
           pronto, erro, overrun, db_estado
  );
endinterface

// File: rtl/interface_ov7670_uc.sv
// Control unit for the OV7670 3x3 sampled capture. It waits for a frame start,
// assembles each RGB565 pixel from two camera bytes, steps pixel and quadrant
// counters and finishes once the 9th sample is stored. Truncated frames are
// retried until MAX_TENTATIVAS consecutive failures, then the unit parks in ERRO.
// Outputs are decoded from the state register (AVANCA counter strobes also look
// at the current-cycle flags), so the async reset forces them all to 0 at once.
module interface_ov7670_uc #(
  parameter int MAX_TENTATIVAS = 3,
  parameter int S_TENT         = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  interface_ov7670_uc_if.master cam
);

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    PREPARA      = 4'd1,
    ESPERA_FRAME = 4'd2,
    ESPERA_A     = 4'd3,
    CAPTURA_A    = 4'd4,
    ESPERA_B     = 4'd5,
    CAPTURA_B    = 4'd6,
    AVANCA       = 4'd7,
    FALHA        = 4'd8,
    FIM          = 4'd9,
    ERRO         = 4'd10
  } state_t;

  localparam logic [S_TENT-1:0] MAX_T = S_TENT'(MAX_TENTATIVAS);

  state_t            state_r;
  state_t            next_state_s;
  logic [S_TENT-1:0] tent_r;
  logic [S_TENT-1:0] tent_inc_s;
  logic              clr_tent_s;
  logic              overrun_r;
  logic              overrun_set_s;

  logic byte_estavel_s;
  logic zera_linha_pixel_s;
  logic zera_coluna_pixel_s;
  logic zera_linha_quadrante_s;
  logic zera_coluna_quadrante_s;
  logic conta_linha_pixel_s;
  logic conta_coluna_pixel_s;
  logic conta_linha_quadrante_s;
  logic conta_coluna_quadrante_s;
  logic pronto_s;
  logic erro_s;

  // a fresh start (from idle or from the error park) restarts the retry budget
  assign clr_tent_s = ((state_r == INICIAL) || (state_r == ERRO)) && cam.iniciar;
  assign tent_inc_s = tent_r + S_TENT'(1);

  // a byte strobe while the unit is busy latching or advancing cannot be used
  assign overrun_set_s = cam.transmite_byte &&
                         ((state_r == CAPTURA_A) || (state_r == CAPTURA_B) || (state_r == AVANCA));

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= INICIAL;
    end else begin
      state_r <= next_state_s;
    end
  end

  // consecutive failed-frame counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tent_r <= '0;
    end else if (clr_tent_s) begin
      tent_r <= '0;
    end else if (state_r == FALHA) begin
      tent_r <= tent_inc_s;
    end else begin
      tent_r <= tent_r;
    end
  end

  // sticky dropped-byte flag, cleared when a new capture attempt is prepared
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_r <= 1'b0;
    end else if (state_r == PREPARA) begin
      overrun_r <= 1'b0;
    end else if (overrun_set_s) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // next-state and output decode
  always_comb begin
    next_state_s             = INICIAL;
    byte_estavel_s           = 1'b0;
    zera_linha_pixel_s       = 1'b0;
    zera_coluna_pixel_s      = 1'b0;
    zera_linha_quadrante_s   = 1'b0;
    zera_coluna_quadrante_s  = 1'b0;
    conta_linha_pixel_s      = 1'b0;
    conta_coluna_pixel_s     = 1'b0;
    conta_linha_quadrante_s  = 1'b0;
    conta_coluna_quadrante_s = 1'b0;
    pronto_s                 = 1'b0;
    erro_s                   = 1'b0;

    case (state_r)
      INICIAL: begin
        if (cam.iniciar) begin
          next_state_s = PREPARA;
        end else begin
          next_state_s = INICIAL;
        end
      end

      PREPARA: begin
        zera_linha_pixel_s      = 1'b1;
        zera_coluna_pixel_s     = 1'b1;
        zera_linha_quadrante_s  = 1'b1;
        zera_coluna_quadrante_s = 1'b1;
        next_state_s            = ESPERA_FRAME;
      end

      ESPERA_FRAME: begin
        // a byte strobe coincident with the frame start belongs to nothing
        if (cam.transmite_frame) begin
          next_state_s = ESPERA_A;
        end else begin
          next_state_s = ESPERA_FRAME;
        end
      end

      ESPERA_A: begin
        // a new frame start mid-capture means the previous frame was cut short
        if (cam.transmite_frame) begin
          next_state_s = FALHA;
        end else if (cam.transmite_byte) begin
          next_state_s = CAPTURA_A;
        end else begin
          next_state_s = ESPERA_A;
        end
      end

      CAPTURA_A: begin
        byte_estavel_s = 1'b1;
        next_state_s   = ESPERA_B;
      end

      ESPERA_B: begin
        if (cam.transmite_frame) begin
          next_state_s = FALHA;
        end else if (cam.transmite_byte) begin
          next_state_s = CAPTURA_B;
        end else begin
          next_state_s = ESPERA_B;
        end
      end

      CAPTURA_B: begin
        // quadrant address is still unchanged here, so this write stores the full pixel
        byte_estavel_s = 1'b1;
        next_state_s   = AVANCA;
      end

      AVANCA: begin
        conta_coluna_pixel_s     = 1'b1;
        conta_linha_pixel_s      = cam.fim_coluna_pixel;
        conta_coluna_quadrante_s = cam.match_pixel;
        conta_linha_quadrante_s  = cam.match_pixel & cam.fim_coluna_quadrante;
        if (cam.match_pixel && cam.fim_coluna_quadrante && cam.fim_linha_quadrante) begin
          next_state_s = FIM;
        end else if (cam.fim_coluna_pixel && cam.fim_linha_pixel) begin
          next_state_s = FALHA;
        end else begin
          next_state_s = ESPERA_A;
        end
      end

      FALHA: begin
        if (tent_inc_s == MAX_T) begin
          next_state_s = ERRO;
        end else begin
          next_state_s = PREPARA;
        end
      end

      FIM: begin
        pronto_s     = 1'b1;
        next_state_s = INICIAL;
      end

      ERRO: begin
        erro_s = 1'b1;
        if (cam.iniciar) begin
          next_state_s = PREPARA;
        end else begin
          next_state_s = ERRO;
        end
      end

      default: begin
        next_state_s = INICIAL;
      end
    endcase
  end

  assign cam.byte_estavel           = byte_estavel_s;
  assign cam.zera_linha_pixel       = zera_linha_pixel_s;
  assign cam.zera_coluna_pixel      = zera_coluna_pixel_s;
  assign cam.zera_linha_quadrante   = zera_linha_quadrante_s;
  assign cam.zera_coluna_quadrante  = zera_coluna_quadrante_s;
  assign cam.conta_linha_pixel      = conta_linha_pixel_s;
  assign cam.conta_coluna_pixel     = conta_coluna_pixel_s;
  assign cam.conta_linha_quadrante  = conta_linha_quadrante_s;
  assign cam.conta_coluna_quadrante = conta_coluna_quadrante_s;
  assign cam.pronto                 = pronto_s;
  assign cam.erro                   = erro_s;
  assign cam.overrun                = overrun_r;
  assign cam.db_estado              = state_r;

endmodule

// File: doc/interface_ov7670_uc.md
# interface_OV7670_uc

Control unit for the OV7670 capture datapath. Sequences one frame capture: waits for the frame-start pulse, assembles each RGB565 pixel from two camera bytes, steps the pixel and quadrant counters, and stops once all 9 sampled pixels are stored in the 3x3 RAM. Sits beside the capture datapath and drives all of its `zera_*`, `conta_*` and `byte_estavel` inputs. Truncated frames are retried up to a bounded count.

## Interface
- `MAX_TENTATIVAS`, default 3: failed frames tolerated before ERRO.
- `S_TENT`, default 2: width of the attempt counter; must hold `MAX_TENTATIVAS`.

- `clock`, in, 1: system clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `iniciar`, in, 1: start request, level-sampled in INICIAL and ERRO.
- `transmite_frame`, in, 1: 1-cycle frame-start pulse.
- `transmite_byte`, in, 1: 1-cycle byte-valid pulse.
- `match_pixel`, in, 1: current pixel (line, column) is a sample point.
- `fim_coluna_pixel`, `fim_linha_pixel`, in, 1 each: pixel counters at their last value.
- `fim_coluna_quadrante`, `fim_linha_quadrante`, in, 1 each: quadrant counters at 2.
- `byte_estavel`, out, 1: latch the camera byte into the pixel register.
- `zera_linha_pixel`, `zera_coluna_pixel`, `zera_linha_quadrante`, `zera_coluna_quadrante`, out, 1 each: clear counters.
- `conta_linha_pixel`, `conta_coluna_pixel`, `conta_linha_quadrante`, `conta_coluna_quadrante`, out, 1 each: increment counters.
- `pronto`, out, 1: 1-cycle pulse when capture completes.
- `erro`, out, 1: high while in ERRO.
- `overrun`, out, 1: sticky flag for a dropped byte pulse.
- `db_estado`, out, 4: state encoding, for debug.

## Operation
States and `db_estado` codes:
- **INICIAL (0)**: all outputs 0. Goes to PREPARA when `iniciar`=1; the attempt counter is cleared on that transition.
- **PREPARA (1)**: all four `zera_*`=1; clears `overrun`. Goes to ESPERA_FRAME.
- **ESPERA_FRAME (2)**: goes to ESPERA_A on `transmite_frame`. A `transmite_byte` arriving in the same cycle is ignored.
- **ESPERA_A (3)**:
  - `transmite_frame` means the frame was truncated: go to FALHA. This has priority over `transmite_byte`.
  - Otherwise `transmite_byte` moves to CAPTURA_A.
- **CAPTURA_A (4)**: `byte_estavel`=1 (high byte). Goes to ESPERA_B.
- **ESPERA_B (5)**: same rules as ESPERA_A; `transmite_byte` moves to CAPTURA_B.
- **CAPTURA_B (6)**: `byte_estavel`=1 (low byte). Goes to AVANCA.
- **AVANCA (7)**: Mealy outputs, decided in this cycle:
  - Always `conta_coluna_pixel`=1.
  - `conta_linha_pixel`=`fim_coluna_pixel`.
  - `conta_coluna_quadrante`=`match_pixel`.
  - `conta_linha_quadrante`=`match_pixel & fim_coluna_quadrante`.
  - Next state:
    - `match_pixel & fim_coluna_quadrante & fim_linha_quadrante` → FIM (9th sample stored).
    - Else `fim_coluna_pixel & fim_linha_pixel` → FALHA (frame ended before the quadrant was full).
    - Else → ESPERA_A.
- **FALHA (8)**: attempt counter +1.
  - If the new count equals `MAX_TENTATIVAS` → ERRO.
  - Else → PREPARA.
- **FIM (9)**: `pronto`=1 for this cycle only. Goes to INICIAL.
- **ERRO (10)**: `erro`=1. Goes to PREPARA when `iniciar`=1; the attempt counter is cleared on that transition.
- Unused encodings go to INICIAL.

Rules:
- `overrun` is set when `transmite_byte`=1 in CAPTURA_A, CAPTURA_B or AVANCA. That pulse is dropped. The flag is cleared only by PREPARA or reset.
- The quadrant address stays constant across both byte writes of a pixel. The datapath write enable (`match & byte_estavel`) therefore stores the full 16-bit pixel on the CAPTURA_B write.
- Asynchronous reset at any point:
  - state → INICIAL, attempt counter → 0, `overrun` → 0.
  - All outputs 0 while `reset`=0, including any capture in flight.

## Timing
- Reset value of every output is 0; `db_estado`=0.
- Moore outputs are decoded from the state register. AVANCA `conta_*` outputs are combinational on the inputs in that cycle.
- Byte pulse seen at cycle t in ESPERA_A:
  - `byte_estavel` high at t+1.
  - ESPERA_B is ready at t+2.
- Byte pulse seen at cycle s in ESPERA_B:
  - `byte_estavel` at s+1.
  - AVANCA at s+2.
  - ESPERA_A ready at s+3.
- Minimum `transmite_byte` spacing is therefore 2 cycles within a pixel and 3 cycles between pixels.
- Latency from `iniciar` to ESPERA_FRAME is 2 cycles.
- `pronto` rises 1 cycle after the AVANCA that stores the 9th sample.

## Test plan
- **Nominal capture**: reset, `iniciar`, frame pulse, then byte pulses every 4 cycles. Assert `match_pixel` at 9 pixels, with the quadrant `fim_*` flags modelled. Expect:
  - 18 `byte_estavel` pulses on the match pixels.
  - `conta_coluna_quadrante` pulsed 9 times, `conta_linha_quadrante` 3 times.
  - `pronto` 1 cycle, then `db_estado`=0.
- **Truncation retry**: second frame pulse while in ESPERA_B. Expect FALHA then PREPARA with all `zera_*`=1, then a successful capture on the next frame with `erro`=0.
- **Retry exhaustion**: 3 consecutive truncated frames with `MAX_TENTATIVAS`=3. Expect:
  - `erro`=1 and `db_estado`=10.
  - `iniciar` then returns to state 1.
- **Overrun**: byte pulses 1 cycle apart. Expect `overrun`=1 after the second pulse, held until the next PREPARA.
- **Frame end without full quadrant**: `fim_coluna_pixel=fim_linha_pixel=1` in AVANCA with only 6 samples stored. Expect FALHA, attempt count 1, and no `pronto`.
- **Mid-capture reset**: `reset`=0 during CAPTURA_B. Expect all outputs 0 and `db_estado`=0 immediately, without waiting for a clock edge.
